// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and result bus between the chip controller (master) and
// seq_restoring_divider (slave).
interface seq_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivZero;
    logic             Overflow;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivZero, Overflow
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivZero, Overflow
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one shift/trial-subtract step per clock, behind a start/done
// handshake. Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module seq_restoring_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_restoring_divider_if.slave div
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rst_meta;
    logic             r_rst_sync;
    logic             w_rst;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divzero;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    // Asserts with rst immediately, releases two clocks later on a clean edge.
    assign w_rst = r_rst_sync;

    assign w_dvs_zero = (div.Divisor == '0);
    assign w_accept   = (r_state == S_IDLE) && !r_busy && div.Start;

`ifdef SIGNED_DIV_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic w_ovf;
    logic r_neg_q;
    logic r_neg_r;
    logic r_ovf;
    logic r_overflow;

    assign w_dvd_neg = div.Dividend[WIDTH-1];
    assign w_dvs_neg = div.Divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -div.Dividend : div.Dividend;
    assign w_dvs_mag = w_dvs_neg ? -div.Divisor : div.Divisor;
    assign w_ovf     = (div.Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&div.Divisor);
`else
    assign w_dvd_mag = div.Dividend;
    assign w_dvs_mag = div.Divisor;
`endif

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_dvs_zero ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    // Shifted remainder stays below 2*divisor: a set top bit alone means the subtraction fits.
    assign w_fits  = w_shift[WIDTH] | ~w_trial[WIDTH];

    always_ff @(posedge clk or posedge w_rst) begin
        // NOTE: datapath registers are reset too, so nothing reads X before the first operation.
        if (w_rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else if (w_load) begin
            r_rem <= w_dvs_zero ? div.Dividend : '0;
            r_quo <= w_dvd_mag;
            r_dvs <= w_dvs_mag;
            r_cnt <= CNT_LOAD;
            r_dz  <= w_dvs_zero;
        end else if (w_step) begin
            r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt - CNT_LAST;
        end
    end

`ifdef SIGNED_DIV_EN
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ovf      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
                r_ovf   <= w_ovf;
            end
            if (w_finish) r_overflow <= r_ovf & ~r_dz;
        end
    end
`endif

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divzero   <= 1'b0;
        end else begin
            r_done <= w_finish;
            // Busy spans the Done cycle, which keeps Start from being accepted there.
            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;
            if (w_finish) begin
                r_divzero <= r_dz;
                if (r_dz) begin
                    r_quotient  <= '1;
                    r_remainder <= r_rem;
                end else begin
`ifdef SIGNED_DIV_EN
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -r_rem : r_rem;
`else
                    r_quotient  <= r_quo;
                    r_remainder <= r_rem;
`endif
                end
            end
        end
    end

    assign div.Busy      = r_busy;
    assign div.Done      = r_done;
    assign div.Quotient  = r_quotient;
    assign div.Remainder = r_remainder;
    assign div.DivZero   = r_divzero;
`ifdef SIGNED_DIV_EN
    assign div.Overflow  = r_overflow;
`else
    assign div.Overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a timing/arithmetic reference model compared
// every cycle, directed cases with literal expectations, then randomized traffic.
module tb_seq_restoring_divider;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int LAT   = WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL1    = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    int   n_dut_done = 0;

    seq_restoring_divider_if #(.WIDTH(WIDTH)) div_if ();

    seq_restoring_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .div (div_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference straight from the operator definitions.
    function automatic void model_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                      output logic dz, output logic ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = ALL1;
            r  = a;
            dz = 1'b1;
        end
`ifdef SIGNED_DIV_EN
        else if (a == MIN_INT && b == ALL1) begin
            q  = MIN_INT;
            r  = '0;
            ov = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        else begin
            q = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Transaction-level timing model: an accepted op finishes LAT (or 1) edges later,
    // Busy stays up through the Done cycle and drops one edge after.
    logic             m_busy = 1'b0, m_done = 1'b0;
    int               m_left = 0;
    int               n_model_ops = 0;
    logic [WIDTH-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic             m_dz = 1'b0, m_ov = 1'b0, p_dz = 1'b0, p_ov = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_q = '0; m_r = '0; m_dz = 1'b0; m_ov = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
                n_model_ops++;
            end
        end else if (div_if.Start === 1'b1) begin
            model_div(div_if.Dividend, div_if.Divisor, p_q, p_r, p_dz, p_ov);
            m_busy = 1'b1;
            m_left = (div_if.Divisor == '0) ? 1 : LAT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", div_if.Busy, m_busy);
            check("done", div_if.Done, m_done);
            check("quotient", div_if.Quotient, m_q);
            check("remainder", div_if.Remainder, m_r);
            check("divzero", div_if.DivZero, m_dz);
            check("overflow", div_if.Overflow, m_ov);
            if (div_if.Done === 1'b1) n_dut_done++;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (div_if.Busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_busy", div_if.Busy, 1'b0);
    endtask

    // Returns at the negedge of the Done cycle; lat counts edges after the accept edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
        wait_idle();
        div_if.Start    = 1'b1;
        div_if.Dividend = a;
        div_if.Divisor  = b;
        @(posedge clk);
        @(negedge clk);
        div_if.Start = 1'b0;
        lat = -1;
        for (int k = 0; k < LAT + 8; k++) begin
            if (div_if.Done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_opnd(input bit is_dvs);
        case ($urandom_range(0, 7))
            0:       return is_dvs ? '0 : WIDTH'($urandom_range(0, 3));
            1:       return WIDTH'(1);
            2:       return ALL1;
            3:       return MIN_INT;
            4:       return WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        int               lat;
        int               ndone;
        int               ops0;
        int               dones0;
        logic [WIDTH-1:0] q, r;
        logic             dz, ov;

        div_if.Start    = 1'b0;
        div_if.Dividend = '0;
        div_if.Divisor  = '0;

        model_div(32'd100, 32'd7, q, r, dz, ov);
        check("model_100_7_q", q, 14);
        check("model_100_7_r", r, 2);
        model_div(32'd1234, 32'd0, q, r, dz, ov);
        check("model_div0_q", q, ALL1);
        check("model_div0_dz", dz, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", div_if.Busy, 1'b0);
        check("rst_done", div_if.Done, 1'b0);
        check("rst_q", div_if.Quotient, 0);
        check("rst_r", div_if.Remainder, 0);
        check("rst_dz", div_if.DivZero, 1'b0);
        check("rst_ov", div_if.Overflow, 1'b0);
        chk_en = 1'b1;
        rst    = 1'b0;
        repeat (4) @(negedge clk);

        run_op(32'd100, 32'd7, lat);
        check("t1_latency", lat, LAT);
        check("t1_q", div_if.Quotient, 14);
        check("t1_r", div_if.Remainder, 2);
        check("t1_dz", div_if.DivZero, 1'b0);
        check("t1_busy_with_done", div_if.Busy, 1'b1);

        run_op(ALL1, 32'd1, lat);
        check("t2a_q", div_if.Quotient, ALL1);
        check("t2a_r", div_if.Remainder, 0);
        run_op(32'd5, 32'd9, lat);
        check("t2b_q", div_if.Quotient, 0);
        check("t2b_r", div_if.Remainder, 5);

        run_op(32'd1234, 32'd0, lat);
        check("t3_latency", lat, 1);
        check("t3_q", div_if.Quotient, ALL1);
        check("t3_r", div_if.Remainder, 1234);
        check("t3_dz", div_if.DivZero, 1'b1);
        run_op(32'd10, 32'd3, lat);
        check("t3b_dz", div_if.DivZero, 1'b0);
        check("t3b_q", div_if.Quotient, 3);
        check("t3b_r", div_if.Remainder, 1);

        // Start held high for 11 cycles; the operand change while busy must be ignored.
        wait_idle();
        div_if.Start    = 1'b1;
        div_if.Dividend = 32'd50;
        div_if.Divisor  = 32'd5;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 6) begin
                div_if.Dividend = 32'd77;
                div_if.Divisor  = 32'd7;
            end
            if (i == 11) div_if.Start = 1'b0;
            @(negedge clk);
            if (div_if.Done === 1'b1) ndone++;
        end
        check("t4_done_count", ndone, 1);
        check("t4_q", div_if.Quotient, 10);
        check("t4_r", div_if.Remainder, 0);

        // Reset in the middle of a run.
        wait_idle();
        div_if.Start    = 1'b1;
        div_if.Dividend = 32'd1000;
        div_if.Divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        div_if.Start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", div_if.Busy, 1'b0);
        check("t5_done", div_if.Done, 1'b0);
        check("t5_q", div_if.Quotient, 0);
        check("t5_r", div_if.Remainder, 0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_if.Done === 1'b1) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run_op(32'd9, 32'd4, lat);
        check("t5b_q", div_if.Quotient, 2);
        check("t5b_r", div_if.Remainder, 1);

`ifdef SIGNED_DIV_EN
        run_op(-32'sd7, 32'd2, lat);
        check("t6a_q", div_if.Quotient, 32'hFFFF_FFFD);
        check("t6a_r", div_if.Remainder, 32'hFFFF_FFFF);
        run_op(32'd7, -32'sd2, lat);
        check("t6b_q", div_if.Quotient, 32'hFFFF_FFFD);
        check("t6b_r", div_if.Remainder, 1);
        run_op(MIN_INT, ALL1, lat);
        check("t6c_q", div_if.Quotient, MIN_INT);
        check("t6c_r", div_if.Remainder, 0);
        check("t6c_ov", div_if.Overflow, 1'b1);
        run_op(32'd10, 32'd3, lat);
        check("t6d_ov", div_if.Overflow, 1'b0);
`endif

        // Random traffic: Start toggles freely, operands change every cycle.
        wait_idle();
        ops0   = n_model_ops;
        dones0 = n_dut_done;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            div_if.Start    = ($urandom_range(0, 2) == 0);
            div_if.Dividend = rnd_opnd(1'b0);
            div_if.Divisor  = rnd_opnd(1'b1);
        end
        div_if.Start = 1'b0;
        wait_idle();
        check("rand_done_count", n_dut_done - dones0, n_model_ops - ops0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
